eviction_write_buffer: RTL and testbench
========================================

# eviction_write_buffer

Line-granular write buffer between the cache hierarchy's memory port and physical memory. Dirty-line writebacks are absorbed in one cycle and drained to physical memory in the background. Read misses bypass queued writebacks, are forwarded from the buffer when the line is resident, and otherwise go to physical memory. Writes to a line already in the buffer coalesce in place, so each line tag appears at most once.

## Interface
- DEPTH, 4, number of 256-bit line entries; power of two, ≥2
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  upstream line read; held until mem_resp
- mem_write  in  1  upstream line writeback; held until mem_resp
- mem_address  in  32  upstream line address; bits [4:0] ignored
- mem_wdata  in  256  upstream writeback data
- mem_resp  out  1  one-cycle completion pulse to upstream
- mem_rdata  out  256  read data; valid when mem_resp=1 for a read
- pmem_read  out  1  physical read; held until pmem_resp
- pmem_write  out  1  physical write; held until pmem_resp
- pmem_address  out  32  physical line address; bits [4:0] always 0
- pmem_wdata  out  256  physical write data
- pmem_resp  in  1  one-cycle completion pulse from physical memory
- pmem_rdata  in  256  physical read data; valid with pmem_resp
- ewb_empty  out  1  high when no entry is valid

## Operation
- Entries are kept as a circular FIFO: head, tail and a count of 0..DEPTH. Each entry holds a valid bit, a 27-bit tag (address[31:5]) and a 256-bit line.
- Match means the entry is valid and its tag equals mem_address[31:5]. Tags are unique, so there is at most one match.
- States: IDLE, PREAD, DRAIN, RESP.
- IDLE arbitrates in this priority order:
  1. **mem_read with match:** latch the matching line into the response register, go to RESP.
  2. **mem_read without match:** go to PREAD.
  3. **mem_write with match:** overwrite that entry's line, go to RESP. FIFO order is unchanged. This applies even when count=DEPTH.
  4. **mem_write, no match, count<DEPTH:** write the tail entry, advance tail, increment count, go to RESP.
  5. **mem_write, no match, count=DEPTH:** go to DRAIN. The write is retried in IDLE after the drain completes.
  6. **No request and count>0:** go to DRAIN.
- PREAD:
  - pmem_read=1 with pmem_address={mem_address[31:5],5'b0}.
  - On pmem_resp, latch pmem_rdata into the response register and go to RESP.
- DRAIN:
  - pmem_write=1 with the head tag and line.
  - On pmem_resp, clear head valid, advance head, decrement count, go to IDLE.
  - A drain in progress is never aborted by a new upstream request.
- RESP: mem_resp=1 for exactly one cycle, then go to IDLE.
- mem_rdata always drives the response register. Its value is don't-care on write responses.
- pmem_read and pmem_write are never both high.

## Timing
- Reset values:
  - State IDLE; count, head and tail 0; all valid bits 0.
  - mem_resp, pmem_read and pmem_write 0; ewb_empty 1.
  - pmem_address, pmem_wdata and mem_rdata are 0.
- Write accepted, or read forwarded, in IDLE at cycle N: mem_resp at N+1.
- Read miss seen at N: pmem_read is high from N+1. If pmem_resp arrives at M, mem_resp is at M+1.
- Upstream requests arriving while in DRAIN wait. Worst-case added latency is one physical write.
- Wrap-around: head and tail wrap modulo DEPTH. The full/empty distinction comes from count, not from pointer equality.
- Because the state returns to IDLE after each RESP, a request still asserted in the RESP cycle is not re-accepted. Upstream must drop the request after mem_resp.
- rst asserted in any state, including mid-PREAD or mid-DRAIN:
  - Returns all state to reset values on the next edge.
  - Buffered lines are discarded.
  - A pending pmem_resp after reset is ignored.

## Configuration
- EWB_READ_FORWARD_EN defined: behaviour as above; a read hit is served from the buffer.
- EWB_READ_FORWARD_EN undefined:
  - A read with a match goes to DRAIN repeatedly until no entry matches, then goes to PREAD.
  - Write coalescing stays enabled.

## Structure
- Shared package ewb_pkg: state enum, line_t (logic [255:0]), tag_t (logic [26:0]), and LINE_OFFSET=5.
- Sub-module ewb_store holds the valid/tag/data arrays, the head/tail/count pointers and the combinational tag match. It outputs the match hit and match index.
- The top level holds the FSM and the response register.

## Test plan
- **Single write, then idle drain:** write 0x0000_1040 with data A → mem_resp 1 cycle later. pmem_write then carries address 0x0000_1040 and data A. After pmem_resp, ewb_empty=1.
- **Read forward:** write 0x2000 with B, then read 0x201C before the drain starts → mem_resp at N+1 with mem_rdata=B. No pmem_read is issued. (Without EWB_READ_FORWARD_EN: the drain of 0x2000 precedes a pmem_read of 0x2000.)
- **Coalesce:** write 0x3000 with C, then 0x3000 with D, with pmem stalled → count stays 1. The subsequent drain writes D once.
- **Full buffer:**
  - Write four distinct lines with pmem stalled, then a fifth write to 0x5000 → drain of the oldest completes first.
  - The fifth mem_resp follows, and FIFO order of the remaining drains is preserved.
- **Read miss:** read 0x6000 with the buffer empty and pmem_resp 10 cycles later carrying E → mem_resp the cycle after pmem_resp, with mem_rdata=E.
- **Reset mid-DRAIN:** assert rst during pmem_write → next cycle all outputs are at reset values and ewb_empty=1. A late pmem_resp causes no state change.

Source files
------------

// File: rtl/ewb_pkg.sv
// Types and constants shared by the eviction write buffer top level and its entry store.
package ewb_pkg;

    localparam int unsigned LINE_OFFSET = 5;
    localparam int unsigned LINE_W      = 256;
    localparam int unsigned TAG_W       = 32 - LINE_OFFSET;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [TAG_W-1:0]  tag_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAD,
        ST_DRAIN,
        ST_RESP
    } ewb_state_e;

    function automatic logic [31:0] tag_addr(input tag_t tag);
        return {tag, {LINE_OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/ewb_store.sv
// Circular FIFO of valid/tag/line entries with head/tail/count pointers and a
// combinational tag lookup (at most one entry can match).
module ewb_store
    import ewb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  tag_t                       lookup_tag,
    input  logic                       push,
    input  logic                       update,
    input  logic                       pop,
    input  logic [$clog2(DEPTH)-1:0]   upd_idx,
    input  tag_t                       wr_tag,
    input  line_t                      wr_data,
    input  logic                       sel_head,
    output logic                       hit,
    output logic [$clog2(DEPTH)-1:0]   hit_idx,
    output tag_t                       head_tag,
    output line_t                      sel_data,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [DEPTH-1:0] valid_q, valid_d;
    tag_t             tag_q  [DEPTH];
    tag_t             tag_d  [DEPTH];
    line_t            data_q [DEPTH];
    line_t            data_d [DEPTH];
    ptr_t             head_q, head_d;
    ptr_t             tail_q, tail_d;
    cnt_t             count_q, count_d;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == lookup_tag)) begin
                hit     = 1'b1;
                hit_idx = ptr_t'(i);
            end
        end
    end

    assign head_tag = tag_q[head_q];
    assign sel_data = sel_head ? data_q[head_q] : data_q[hit_idx];
    // Full/empty come from the count; head==tail is ambiguous on its own.
    assign full     = (count_q == cnt_t'(DEPTH));
    assign empty    = (count_q == '0);

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (update) begin
            data_d[upd_idx] = wr_data;
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tag_d[tail_q]   = wr_tag;
            data_d[tail_q]  = wr_data;
            tail_d          = tail_q + ptr_t'(1);
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + ptr_t'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/eviction_write_buffer.sv
// Line-granular write buffer between the cache memory port and physical memory.
// EWB_READ_FORWARD_EN: when defined, read hits are served from the buffer; otherwise the buffer drains until the line is gone.
module eviction_write_buffer
    import ewb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [255:0] mem_wdata,
    output logic         mem_resp,
    output logic [255:0] mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [255:0] pmem_rdata,
    output logic         ewb_empty
);

    ewb_state_e state_q, state_d;
    line_t      resp_q, resp_d;

    tag_t                     req_tag;
    tag_t                     head_tag;
    line_t                    sel_data;
    logic                     hit, full, empty;
    logic                     push, update, pop;
    logic [$clog2(DEPTH)-1:0] hit_idx;
    logic                     unused_offset;

    assign req_tag       = mem_address[31:LINE_OFFSET];
    assign unused_offset = ^mem_address[LINE_OFFSET-1:0];

    ewb_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .lookup_tag (req_tag),
        .push       (push),
        .update     (update),
        .pop        (pop),
        .upd_idx    (hit_idx),
        .wr_tag     (req_tag),
        .wr_data    (mem_wdata),
        .sel_head   (state_q == ST_DRAIN),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .head_tag   (head_tag),
        .sel_data   (sel_data),
        .full       (full),
        .empty      (empty)
    );

    always_comb begin
        state_d = state_q;
        resp_d  = resp_q;
        push    = 1'b0;
        update  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_read) begin
                    if (hit) begin
`ifdef EWB_READ_FORWARD_EN
                        resp_d  = sel_data;
                        state_d = ST_RESP;
`else
                        state_d = ST_DRAIN;
`endif
                    end else begin
                        state_d = ST_PREAD;
                    end
                end else if (mem_write) begin
                    if (hit) begin
                        update  = 1'b1;
                        state_d = ST_RESP;
                    end else if (!full) begin
                        push    = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (!empty) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_PREAD: begin
                if (pmem_resp) begin
                    resp_d  = pmem_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_DRAIN: begin
                if (pmem_resp) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_resp     = (state_q == ST_RESP);
        pmem_read    = (state_q == ST_PREAD);
        pmem_write   = (state_q == ST_DRAIN);
        pmem_address = '0;
        pmem_wdata   = '0;
        if (state_q == ST_PREAD) begin
            pmem_address = tag_addr(req_tag);
        end else if (state_q == ST_DRAIN) begin
            pmem_address = tag_addr(head_tag);
            pmem_wdata   = sel_data;
        end
    end

    assign mem_rdata = resp_q;
    assign ewb_empty = empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
        end
    end

endmodule

// File: tb/tb_eviction_write_buffer.sv
// Scoreboard bench for eviction_write_buffer: memory-image reference model plus a pmem responder.
module tb_eviction_write_buffer;

    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic         mem_resp;
    logic [255:0] mem_rdata;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;
    logic         ewb_empty;

    eviction_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .ewb_empty    (ewb_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_read;
        logic [26:0]  tag;
        logic [255:0] data;
    } exp_t;

    typedef struct {
        logic [26:0]  tag;
        logic [255:0] data;
    } ent_t;

    exp_t         exp_q [$];
    ent_t         mq [$];
    logic [255:0] phys [logic [26:0]];

    int unsigned checks = 0, errors = 0;
    int unsigned cyc = 0, n_pwrites = 0, n_preads = 0, pr_cyc = 0, start_cyc = 0;
    int unsigned fixed_lat = 0, inject_req = 0, inject_done = 0;
    bit          hold = 1'b0, rand_stall_en = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [255:0] dflt(input logic [26:0] t);
        return {8{{5'b0, t} ^ 32'h5A5A_0000}};
    endfunction

    function automatic int mq_find(input logic [26:0] t);
        foreach (mq[i]) if (mq[i].tag == t) return i;
        return -1;
    endfunction

    function automatic logic [255:0] model_lookup(input logic [26:0] t);
        int k;
        k = mq_find(t);
        if (k >= 0) return mq[k].data;
        if (phys.exists(t)) return phys[t];
        return dflt(t);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // pmem responder (posedge + 1) and response/flag monitor (negedge)
    initial begin : pmem_and_monitor
        bit          busy;
        int unsigned wait_cnt, lat;
        exp_t        e;
        ent_t        ent;
        int          k;
        busy = 1'b0; wait_cnt = 0; lat = 0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            pmem_resp = 1'b0;
            if (rst) begin
                busy = 1'b0;
                wait_cnt = 0;
            end else if (inject_req != inject_done) begin
                pmem_resp = 1'b1;
                inject_done++;
            end else if (pmem_read || pmem_write) begin
                if (!busy) begin
                    busy = 1'b1; wait_cnt = 0; start_cyc = cyc;
                    lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(0, 3);
                    if (rand_stall_en && $urandom_range(0, 5) == 0) lat += $urandom_range(5, 15);
                end
                if (!hold) begin
                    if (wait_cnt >= lat) begin
                        busy = 1'b0; pmem_resp = 1'b1; pr_cyc = cyc;
                        chk("pmem_addr_low", 256'(pmem_address[4:0]), 256'(0));
                        if (pmem_write) begin
                            if (mq.size() == 0) begin
                                chk("drain_unexpected", 256'(1), 256'(0));
                            end else begin
                                ent = mq.pop_front();
                                chk("drain_tag", 256'(pmem_address[31:5]), 256'(ent.tag));
                                chk("drain_data", pmem_wdata, ent.data);
                            end
                            phys[pmem_address[31:5]] = pmem_wdata;
                            n_pwrites++;
                        end else begin
                            chk("pread_stale", 256'(mq_find(pmem_address[31:5]) >= 0), 256'(0));
                            if (exp_q.size() > 0) chk("pread_tag", 256'(pmem_address[31:5]), 256'(exp_q[0].tag));
                            pmem_rdata = phys.exists(pmem_address[31:5]) ? phys[pmem_address[31:5]]
                                                                         : dflt(pmem_address[31:5]);
                            n_preads++;
                        end
                    end else begin
                        wait_cnt++;
                    end
                end
            end
            @(negedge clk);
            chk("pmem_exclusive", 256'(pmem_read && pmem_write), 256'(0));
            if (rst) begin
                mq.delete();
            end else begin
                if (mem_resp) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_resp", 256'(1), 256'(0));
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_read) begin
                            chk("read_data", mem_rdata, e.data);
                        end else begin
                            k = mq_find(e.tag);
                            if (k >= 0) mq[k].data = e.data;
                            else mq.push_back('{tag: e.tag, data: e.data});
                            chk("occupancy", 256'(mq.size() <= DEPTH), 256'(1));
                        end
                    end
                end
                if (!pmem_resp) chk("empty_flag", 256'(ewb_empty), 256'(mq.size() == 0));
            end
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after mem_resp.
    task automatic do_req(input bit rd, input logic [31:0] a, input logic [255:0] d,
                          output int unsigned ic, output int unsigned rc);
        exp_t        e;
        int unsigned n;
        e.is_read = rd;
        e.tag     = a[31:5];
        e.data    = rd ? model_lookup(a[31:5]) : d;
        exp_q.push_back(e);
        mem_address = a;
        mem_wdata   = rd ? rand_line() : d;
        mem_read    = rd;
        mem_write   = !rd;
        ic = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_resp && n < 400);
        if (!mem_resp) begin
            checks++; errors++;
            $display("FAIL req_timeout: no mem_resp for addr %0h after %0d cycles", a, n);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
        rc = cyc;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int unsigned n;
        n = 0;
        while (!(ewb_empty && !pmem_write && !pmem_read && !mem_resp) && n < 500) begin
            idle(1);
            n++;
        end
        chk(name, 256'(ewb_empty), 256'(1));
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int unsigned  ic, rc, pw0, pr0;
        logic [255:0] la, lb, lc, ld, le, lf;
        logic [31:0]  a;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
        la = rand_line(); lb = rand_line(); lc = rand_line();
        ld = rand_line(); le = rand_line(); lf = rand_line();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_resp", 256'(mem_resp), 256'(0));
        chk("rst_pmem_read", 256'(pmem_read), 256'(0));
        chk("rst_pmem_write", 256'(pmem_write), 256'(0));
        chk("rst_empty", 256'(ewb_empty), 256'(1));
        chk("rst_pmem_addr", 256'(pmem_address), 256'(0));
        chk("rst_pmem_wdata", pmem_wdata, 256'(0));
        chk("rst_mem_rdata", mem_rdata, 256'(0));
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // single write, then idle drain
        hold = 1'b1;
        do_req(1'b0, 32'h0000_1040, la, ic, rc);
        chk("wr_latency", 256'(rc), 256'(ic + 1));
        idle(1);
        chk("drain_pwrite", 256'(pmem_write), 256'(1));
        chk("drain_paddr", 256'(pmem_address), 256'(32'h0000_1040));
        chk("drain_pwdata", pmem_wdata, la);
        hold = 1'b0;
        wait_empty("empty_after_drain");

        // read hit after a write
        pw0 = n_pwrites; pr0 = n_preads;
        do_req(1'b0, 32'h0000_2000, lb, ic, rc);
        do_req(1'b1, 32'h0000_201C, '0, ic, rc);
`ifdef EWB_READ_FORWARD_EN
        chk("fwd_latency", 256'(rc), 256'(ic + 1));
        chk("fwd_no_pread", 256'(n_preads - pr0), 256'(0));
`else
        chk("nofwd_drain_first", 256'(n_pwrites - pw0), 256'(1));
        chk("nofwd_one_pread", 256'(n_preads - pr0), 256'(1));
`endif
        wait_empty("empty_after_fwd");

        // coalesce
        hold = 1'b1;
        pw0 = n_pwrites;
        do_req(1'b0, 32'h0000_3000, lc, ic, rc);
        do_req(1'b0, 32'h0000_3000, ld, ic, rc);
        hold = 1'b0;
        wait_empty("empty_after_coalesce");
        chk("coalesce_one_drain", 256'(n_pwrites - pw0), 256'(1));

        // full buffer
        hold = 1'b1;
        pw0 = n_pwrites;
        for (int i = 0; i < 4; i++) begin
            a = 32'h0000_4000 + 32'(i * 32);
            do_req(1'b0, a, rand_line(), ic, rc);
        end
        fork
            do_req(1'b0, 32'h0000_5000, le, ic, rc);
            begin idle(6); hold = 1'b0; end
        join
        chk("full_oldest_first", 256'(n_pwrites - pw0), 256'(1));
        wait_empty("empty_after_full");
        chk("full_total_drains", 256'(n_pwrites - pw0), 256'(5));

        // read miss with slow pmem
        fixed_lat = 10;
        do_req(1'b1, 32'h0000_6000, '0, ic, rc);
        chk("pread_start", 256'(start_cyc), 256'(ic + 1));
        chk("miss_latency", 256'(rc), 256'(pr_cyc + 1));
        fixed_lat = 0;

        // reset mid-DRAIN, then a late pmem_resp
        hold = 1'b1;
        do_req(1'b0, 32'h0000_7000, lf, ic, rc);
        idle(1);
        chk("pre_rst_drain", 256'(pmem_write), 256'(1));
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_mem_resp", 256'(mem_resp), 256'(0));
        chk("mid_rst_pmem_write", 256'(pmem_write), 256'(0));
        chk("mid_rst_pmem_read", 256'(pmem_read), 256'(0));
        chk("mid_rst_pmem_addr", 256'(pmem_address), 256'(0));
        chk("mid_rst_pmem_wdata", pmem_wdata, 256'(0));
        chk("mid_rst_mem_rdata", mem_rdata, 256'(0));
        chk("mid_rst_empty", 256'(ewb_empty), 256'(1));
        #2 rst = 1'b0;
        hold = 1'b0;
        inject_req++;
        repeat (3) @(negedge clk);
        chk("late_resp_empty", 256'(ewb_empty), 256'(1));
        chk("late_resp_no_pwrite", 256'(pmem_write), 256'(0));
        chk("late_resp_no_resp", 256'(mem_resp), 256'(0));
        @(posedge clk); #1;
        do_req(1'b1, 32'h0000_7000, '0, ic, rc);

        // randomized traffic over a small set of lines
        rand_stall_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            a = 32'h0008_0000 + 32'($urandom_range(0, 5) * 32) + 32'($urandom_range(0, 31));
            do_req($urandom_range(0, 9) < 4, a, rand_line(), ic, rc);
            idle($urandom_range(0, 3));
        end
        rand_stall_en = 1'b0;
        wait_empty("final_empty");
        chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
